// File: rtl/adder_arbiter_if.sv
// Request/response bundle between compute units, the round-robin arbiter and the shared adder.
// slave = arbiter side, master = requesters plus adder side.
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
);
    localparam int IFW = $clog2(LATENCY + 1);

    logic                     issue_en;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_in1;
    logic [NUM_REQ*WIDTH-1:0] req_in2;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         add_in1;
    logic [WIDTH-1:0]         add_in2;
    logic [WIDTH-1:0]         add_out;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_data;
    logic [IFW-1:0]           inflight;
    logic                     idle;

    modport slave (
        input  issue_en, req_valid, req_in1, req_in2, add_out,
        output req_ready, add_in1, add_in2, resp_valid, resp_data, inflight, idle
    );

    modport master (
        output issue_en, req_valid, req_in1, req_in2, add_out,
        input  req_ready, add_in1, add_in2, resp_valid, resp_data, inflight, idle
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined adder, with a valid/tag shadow pipe.
// Optional perf counters enabled by defining ADDER_ARBITER_PERF_EN.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    adder_arbiter_if.slave             bus
`ifdef ADDER_ARBITER_PERF_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] perf_sel,
    input  logic                       perf_clr,
    output logic [15:0]                perf_grant_cnt,
    output logic [15:0]                perf_stall_cnt
`endif
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int IFW   = $clog2(LATENCY + 1);

    logic [TAG_W-1:0]   r_rr_ptr;
    logic [LATENCY-1:0] r_vld;
    logic [TAG_W-1:0]   r_tag [LATENCY];
    logic [IFW-1:0]     r_inflight;

    logic [NUM_REQ-1:0] w_req_eff;
    logic               w_hi_any;
    logic [TAG_W-1:0]   w_hi_idx;
    logic               w_grant_any;
    logic [TAG_W-1:0]   w_lo_idx;
    logic [TAG_W-1:0]   w_grant_idx;
    logic               w_retire;

    // Gating with reset keeps grants and operands at zero while reset is held.
    assign w_req_eff = (reset && bus.issue_en) ? bus.req_valid : '0;

    // Lowest request at or above the pointer wins; otherwise lowest overall (wrap).
    always_comb begin
        w_hi_any    = 1'b0;
        w_hi_idx    = '0;
        w_grant_any = 1'b0;
        w_lo_idx    = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_req_eff[j]) begin
                w_grant_any = 1'b1;
                w_lo_idx    = TAG_W'(j);
                if (TAG_W'(j) >= r_rr_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = TAG_W'(j);
                end
            end
        end
    end

    assign w_grant_idx   = w_hi_any ? w_hi_idx : w_lo_idx;
    assign w_retire      = r_vld[LATENCY-1];

    assign bus.req_ready = w_grant_any ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign bus.add_in1   = w_grant_any ? bus.req_in1[w_grant_idx*WIDTH +: WIDTH] : '0;
    assign bus.add_in2   = w_grant_any ? bus.req_in2[w_grant_idx*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_vld      <= '0;
            r_inflight <= '0;
            for (int k = 0; k < LATENCY; k++) r_tag[k] <= '0;
        end else begin
            if (w_grant_any)
                r_rr_ptr <= (w_grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + TAG_W'(1);
            r_vld[0] <= w_grant_any;
            r_tag[0] <= w_grant_idx;
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_tag[k] <= r_tag[k-1];
            end
            r_inflight <= r_inflight + IFW'(w_grant_any) - IFW'(w_retire);
        end
    end

    // Adder data is unreset; only the shadow valid decides whether a result is delivered.
    assign bus.resp_valid = w_retire ? (NUM_REQ'(1) << r_tag[LATENCY-1]) : '0;
    assign bus.resp_data  = w_retire ? bus.add_out : '0;
    assign bus.inflight   = r_inflight;
    assign bus.idle       = (r_inflight == '0) && (bus.req_valid == '0);

`ifdef ADDER_ARBITER_PERF_EN
    logic [15:0] r_grant_cnt [NUM_REQ];
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
            r_stall_cnt <= '0;
        end else if (perf_clr) begin
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_grant_any && (r_grant_cnt[w_grant_idx] != 16'hFFFF))
                r_grant_cnt[w_grant_idx] <= r_grant_cnt[w_grant_idx] + 16'd1;
            if ((bus.req_valid != '0) && !w_grant_any && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign perf_grant_cnt = (int'(perf_sel) < NUM_REQ) ? r_grant_cnt[perf_sel] : '0;
    assign perf_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed issues push expected responses, a monitor pops them.
module tb_adder_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int L  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    adder_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(L)) bus ();

`ifdef ADDER_ARBITER_PERF_EN
    logic [1:0]  perf_sel = '0;
    logic        perf_clr = 1'b0;
    logic [15:0] perf_grant_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(L)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef ADDER_ARBITER_PERF_EN
        ,
        .perf_sel(perf_sel),
        .perf_clr(perf_clr),
        .perf_grant_cnt(perf_grant_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Shared adder model: unreset, fixed latency
    logic [W-1:0] add_pipe [L];
    always @(posedge clock) begin
        add_pipe[0] <= bus.add_in1 + bus.add_in2;
        for (int k = 1; k < L; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign bus.add_out = add_pipe[L-1];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int           tag;
        logic [W-1:0] data;
        int           due;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.resp_valid !== '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_valid", 64'(bus.resp_valid), 64'(1) << e.tag);
                    chk("resp_data", 64'(bus.resp_data), 64'(e.data));
                    chk("resp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("resp_missing", 64'(bus.resp_valid), 64'(1) << q[0].tag);
                void'(q.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid[i]     = v;
        bus.req_in1[i*W +: W] = a;
        bus.req_in2[i*W +: W] = b;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the grant this cycle; if one is expected, queue its response.
    task automatic step(input string nm, input logic [NR-1:0] exp_rdy, input int tag, input logic [W-1:0] sum);
        @(negedge clock);
        chk(nm, 64'(bus.req_ready), 64'(exp_rdy));
        if (exp_rdy != '0) q.push_back('{tag, sum, cyc + L});
        tick();
    endtask

    initial begin
        bus.issue_en  = 1'b1;
        bus.req_valid = '1;
        bus.req_in1   = '1;
        bus.req_in2   = '1;

        // Reset state with requests pending
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_inflight", 64'(bus.inflight), 64'd0);
        chk("rst_add_in1", 64'(bus.add_in1), 64'd0);
        chk("rst_add_in2", 64'(bus.add_in2), 64'd0);
        bus.req_valid = '0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk("idle_empty", 64'(bus.idle), 64'd1);
        tick();

        // Single request from requester 2
        set_req(2, 1'b1, 32'd5, 32'd7);
        @(negedge clock);
        chk("t1_ready", 64'(bus.req_ready), 64'b0100);
        chk("t1_add_in1", 64'(bus.add_in1), 64'd5);
        chk("t1_add_in2", 64'(bus.add_in2), 64'd7);
        q.push_back('{2, 32'd12, cyc + L});
        tick();
        set_req(2, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("t1_inflight", 64'(bus.inflight), 64'd1);
            tick();
        end
        @(negedge clock);
        chk("t1_inflight_done", 64'(bus.inflight), 64'd0);
        chk("t1_idle", 64'(bus.idle), 64'd1);
        tick();

        // Fairness from reset: all four requesting for 8 cycles
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, W'(100 + i), W'(1000 * i));
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("rr_ready", 64'(bus.req_ready), 64'(1) << (k % NR));
            chk("rr_inflight", 64'(bus.inflight), 64'((k < L) ? k : L));
            q.push_back('{k % NR, W'(100 + (k % NR) + 1000 * (k % NR)), cyc + L});
            tick();
        end
        bus.req_valid = '0;
        @(negedge clock);
        chk("rr_inflight_sat", 64'(bus.inflight), 64'd4);
        repeat (5) tick();

        // Wrap: truncated sum, then pointer wrap back to 0
        set_req(3, 1'b1, 32'hFFFF_FFFF, 32'd1);
        step("wrap_g3", 4'b1000, 3, 32'd0);
        set_req(0, 1'b1, 32'd9, 32'd10);
        set_req(3, 1'b1, 32'd20, 32'd22);
        step("wrap_g0", 4'b0001, 0, 32'd19);
        set_req(0, 1'b0, 32'd0, 32'd0);
        step("wrap_g3b", 4'b1000, 3, 32'd42);
        set_req(3, 1'b0, 32'd0, 32'd0);

        // issue_en low: no grants, pending results still return
        set_req(1, 1'b1, 32'd3, 32'd4);
        bus.issue_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("noiss_ready", 64'(bus.req_ready), 64'd0);
            chk("noiss_add_in1", 64'(bus.add_in1), 64'd0);
            chk("noiss_add_in2", 64'(bus.add_in2), 64'd0);
            chk("noiss_idle", 64'(bus.idle), 64'd0);
            tick();
        end
        bus.issue_en = 1'b1;
        step("noiss_g1", 4'b0010, 1, 32'd7);
        set_req(1, 1'b0, 32'd0, 32'd0);
        repeat (6) tick();

        // Reset mid-cycle with three ops in flight
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, W'(100 + i), W'(1000 * i));
        step("mrst_g2", 4'b0100, 2, 32'd2102);
        step("mrst_g3", 4'b1000, 3, 32'd3103);
        step("mrst_g0", 4'b0001, 0, 32'd100);
        #3;
        reset = 1'b0;
        #1;
        chk("mrst_ready", 64'(bus.req_ready), 64'd0);
        chk("mrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("mrst_inflight", 64'(bus.inflight), 64'd0);
        q.delete();
        bus.req_valid = '0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("mrst_stale", 64'(bus.resp_valid), 64'd0);
            tick();
        end

`ifdef ADDER_ARBITER_PERF_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(1, 1'b1, 32'd0, 32'd0);
        for (int k = 0; k < 70000; k++) step("perf_g1", 4'b0010, 1, 32'd0);
        bus.issue_en = 1'b0;
        repeat (2) tick();
        set_req(1, 1'b0, 32'd0, 32'd0);
        bus.issue_en = 1'b1;
        perf_sel = 2'd1;
        @(negedge clock);
        chk("perf_grant_sat", 64'(perf_grant_cnt), 64'hFFFF);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd2);
        tick();
        perf_sel = 2'd0;
        @(negedge clock);
        chk("perf_grant0", 64'(perf_grant_cnt), 64'd0);
        tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        perf_sel = 2'd1;
        @(negedge clock);
        chk("perf_clr_grant", 64'(perf_grant_cnt), 64'd0);
        chk("perf_clr_stall", 64'(perf_stall_cnt), 64'd0);
        tick();
`endif

        for (int k = 0; k < 20 && q.size() > 0; k++) tick();
        chk("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
